// File: rtl/mm_master_arbiter_if.sv
// Requester-side and write/read-master-side signals of mm_master_arbiter.
// master modport is the arbiter's view; slave modport is the clients plus master instances.
interface mm_master_arbiter_if #(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32
);
  logic [1:0]                  req_valid;
  logic [1:0]                  req_write;
  logic [2*ADDRESSWIDTH-1:0]   req_address;
  logic [2*DATAWIDTH-1:0]      req_wdata;
  logic [1:0]                  req_ready;
  logic [1:0]                  rsp_valid;
  logic [DATAWIDTH-1:0]        rsp_rdata;
  logic                        rsp_error;
  logic                        busy;

  logic                        write_control_done;
  logic                        write_control_fixed_location;
  logic [ADDRESSWIDTH-1:0]     write_control_write_base;
  logic [ADDRESSWIDTH-1:0]     write_control_write_length;
  logic                        write_control_go;
  logic                        write_user_write_buffer;
  logic [DATAWIDTH-1:0]        write_user_buffer_data;
  logic                        write_user_buffer_full;

  logic                        read_control_done;
  logic                        read_control_fixed_location;
  logic [ADDRESSWIDTH-1:0]     read_control_read_base;
  logic [ADDRESSWIDTH-1:0]     read_control_read_length;
  logic                        read_control_go;
  logic                        read_user_read_buffer;
  logic [DATAWIDTH-1:0]        read_user_buffer_output_data;
  logic                        read_user_data_available;

  modport master (
    input  req_valid, req_write, req_address, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
    input  write_control_done, write_user_buffer_full,
    output write_control_fixed_location, write_control_write_base, write_control_write_length,
    output write_control_go, write_user_write_buffer, write_user_buffer_data,
    input  read_control_done, read_user_buffer_output_data, read_user_data_available,
    output read_control_fixed_location, read_control_read_base, read_control_read_length,
    output read_control_go, read_user_read_buffer
  );

  modport slave (
    output req_valid, req_write, req_address, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy,
    output write_control_done, write_user_buffer_full,
    input  write_control_fixed_location, write_control_write_base, write_control_write_length,
    input  write_control_go, write_user_write_buffer, write_user_buffer_data,
    output read_control_done, read_user_buffer_output_data, read_user_data_available,
    input  read_control_fixed_location, read_control_read_base, read_control_read_length,
    input  read_control_go, read_user_read_buffer
  );
endinterface

// File: rtl/mm_master_arbiter.sv
// Round-robin arbiter sharing one write master and one read master between two single-word
// requesters; one transaction in flight, grant->rsp 4 cycles (write) / 5 (read) minimum.
module mm_master_arbiter #(
  parameter int ADDRESSWIDTH    = 28,
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  mm_master_arbiter_if.master  bus
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WR_PUSH, WR_WAIT, RD_GO, RD_WAIT, RD_POP, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    id_q, id_d;
  logic                    wr_q, wr_d;
  logic                    last_grant_q, last_grant_d;
  logic                    err_q, err_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0]    wdata_q, wdata_d;
  logic [DATAWIDTH-1:0]    rdata_q, rdata_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic       grant_id;
  logic [1:0] ready;
  logic [1:0] rsp;
  logic       wr_go, wr_push, rd_go, rd_pop;
  logic       timed_out;

  // Alternate only under contention; a lone requester always wins.
  assign grant_id  = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
  assign timed_out = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    ready        = '0;
    rsp          = '0;
    wr_go        = 1'b0;
    wr_push      = 1'b0;
    rd_go        = 1'b0;
    rd_pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid && !reset) begin
          ready[grant_id] = 1'b1;
          id_d    = grant_id;
          wr_d    = bus.req_write[grant_id];
          addr_d  = grant_id ? bus.req_address[2*ADDRESSWIDTH-1:ADDRESSWIDTH]
                             : bus.req_address[ADDRESSWIDTH-1:0];
          wdata_d = grant_id ? bus.req_wdata[2*DATAWIDTH-1:DATAWIDTH]
                             : bus.req_wdata[DATAWIDTH-1:0];
          state_d = bus.req_write[grant_id] ? WR_PUSH : RD_GO;
        end
      end
      WR_PUSH: begin
        if (!bus.write_user_buffer_full) begin
          wr_go   = 1'b1;
          wr_push = 1'b1;
          cnt_d   = '0;
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // done is still high from the previous transfer during the first wait cycle
        if (cnt_q != '0 && bus.write_control_done) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RD_GO: begin
        rd_go   = 1'b1;
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0 && bus.read_control_done && bus.read_user_data_available) begin
          state_d = RD_POP;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RD_POP: begin
        rd_pop  = 1'b1;
        rdata_d = bus.read_user_buffer_output_data;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        rsp[id_q]    = 1'b1;
        last_grant_d = id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      id_q         <= 1'b0;
      wr_q         <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      wr_q         <= wr_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;
  assign bus.busy      = (state_q != IDLE);

  assign bus.write_control_fixed_location = 1'b1;
  assign bus.write_control_write_base     = addr_q;
  assign bus.write_control_write_length   = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  assign bus.write_control_go             = wr_go;
  assign bus.write_user_write_buffer      = wr_push;
  assign bus.write_user_buffer_data       = wdata_q;

  assign bus.read_control_fixed_location = 1'b1;
  assign bus.read_control_read_base      = addr_q;
  assign bus.read_control_read_length    = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  assign bus.read_control_go             = rd_go;
  assign bus.read_user_read_buffer       = rd_pop;
endmodule

// File: tb/tb_mm_master_arbiter.sv
// Directed bench for mm_master_arbiter with a small write/read master model; inputs change
// just after posedge, outputs are sampled on negedge.
module tb_mm_master_arbiter;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int BEW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mm_master_arbiter_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) bus ();
  mm_master_arbiter #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .BYTEENABLEWIDTH(BEW), .TIMEOUT_CYCLES(TO))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // staged requester/buffer inputs, applied just after the next posedge
  logic [1:0]      valid_nx, write_nx;
  logic [2*AW-1:0] addr_nx;
  logic [2*DW-1:0] wdata_nx;
  logic            full_nx;
  bit              auto_drop;

  // master model: mode 0 = done 2 cycles after go, 1 = done always high, 2 = never done
  int              wr_mode, rd_mode, wr_pend, rd_pend;
  bit              pop_pend;
  logic [DW-1:0]   rd_val;

  int              grant_cyc[$];
  bit              grant_id[$];
  int              rsp_cyc[$];
  bit              rsp_id[$];
  logic [DW-1:0]   rsp_rd[$];
  bit              rsp_err[$];
  logic [AW-1:0]   go_bases[$];
  int              wr_go_n, push_n, rd_go_n, pop_n, wr_go_cyc, rd_go_cyc;
  int              push_full_err, overlap_err;
  logic [AW-1:0]   rd_base_log;
  logic [DW-1:0]   push_data_log;

  task automatic clear_logs();
    grant_cyc.delete(); grant_id.delete(); rsp_cyc.delete(); rsp_id.delete();
    rsp_rd.delete(); rsp_err.delete(); go_bases.delete();
    wr_go_n = 0; push_n = 0; rd_go_n = 0; pop_n = 0; wr_go_cyc = -1; rd_go_cyc = -1;
    push_full_err = 0; overlap_err = 0; rd_base_log = '0; push_data_log = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.req_valid = valid_nx;
    bus.req_write = write_nx;
    bus.req_address = addr_nx;
    bus.req_wdata = wdata_nx;
    bus.write_user_buffer_full = full_nx;
    bus.read_user_buffer_output_data = rd_val;
    if (wr_mode == 0 && wr_pend > 0) begin
      wr_pend--;
      bus.write_control_done = (wr_pend == 0);
    end
    if (rd_mode == 2) begin
      bus.read_control_done = 1'b0;
      bus.read_user_data_available = 1'b0;
      rd_pend = 0;
    end else if (rd_pend > 0) begin
      rd_pend--;
      bus.read_control_done = (rd_pend == 0);
      bus.read_user_data_available = (rd_pend == 0);
    end
    if (pop_pend) begin
      bus.read_user_data_available = 1'b0;
      pop_pend = 0;
    end
    @(negedge clk);
    if (|bus.req_ready) begin
      grant_cyc.push_back(cyc);
      grant_id.push_back(bus.req_ready[1]);
      if (bus.req_ready == 2'b11 || bus.busy) overlap_err++;
      if (auto_drop) valid_nx = valid_nx & ~bus.req_ready;
    end
    if (bus.write_control_go) begin
      wr_go_n++; wr_go_cyc = cyc; go_bases.push_back(bus.write_control_write_base);
      if (wr_mode == 0) wr_pend = 2;
    end
    if (bus.write_user_write_buffer) begin
      push_n++; push_data_log = bus.write_user_buffer_data;
      if (bus.write_user_buffer_full) push_full_err++;
    end
    if (bus.read_control_go) begin
      rd_go_n++; rd_go_cyc = cyc; rd_base_log = bus.read_control_read_base;
      if (rd_mode == 0) rd_pend = 2;
    end
    if (bus.read_user_read_buffer) begin
      pop_n++; pop_pend = 1;
    end
    if (|bus.rsp_valid) begin
      rsp_cyc.push_back(cyc);
      rsp_id.push_back(bus.rsp_valid[1]);
      rsp_rd.push_back(bus.rsp_rdata);
      rsp_err.push_back(bus.rsp_error);
      if (bus.rsp_valid == 2'b11) overlap_err++;
    end
    if (grant_cyc.size() - rsp_cyc.size() > 1) overlap_err++;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget && rsp_cyc.size() < n; i++) tick();
  endtask

  task automatic wait_grant(input int n, input int budget);
    for (int i = 0; i < budget && grant_cyc.size() < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_nx = '0; write_nx = '0; addr_nx = '0; wdata_nx = '0; full_nx = 1'b0;
    bus.req_valid = '0; bus.req_write = '0; bus.req_address = '0; bus.req_wdata = '0;
    bus.write_user_buffer_full = 1'b0;
    bus.write_control_done = 1'b1;
    bus.read_control_done = 1'b1;
    bus.read_user_data_available = 1'b0;
    bus.read_user_buffer_output_data = '0;
    wr_pend = 0; rd_pend = 0; pop_pend = 0; rd_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    wr_mode = 0; rd_mode = 0; auto_drop = 1;
    reset = 1'b1;
    bus.req_valid = 2'b11; bus.req_write = 2'b01;
    bus.req_address = {28'h0000B00, 28'h0000A00}; bus.req_wdata = {32'h11111111, 32'h22222222};
    bus.write_user_buffer_full = 1'b0; bus.write_control_done = 1'b1;
    bus.read_control_done = 1'b1; bus.read_user_data_available = 1'b1;
    bus.read_user_buffer_output_data = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b want=00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b want=00", bus.rsp_valid); end
    checks++; if ({bus.write_control_go, bus.write_user_write_buffer, bus.read_control_go, bus.read_user_read_buffer} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes got=%b want=0000",
        {bus.write_control_go, bus.write_user_write_buffer, bus.read_control_go, bus.read_user_read_buffer}); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h want=0", bus.rsp_rdata); end
    checks++; if (bus.rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp_error got=%b want=0", bus.rsp_error); end
    checks++; if (bus.write_control_write_base !== 28'h0 || bus.read_control_read_base !== 28'h0) begin
      failures++; $display("FAIL reset_base got=%h/%h want=0/0", bus.write_control_write_base, bus.read_control_read_base); end
    checks++; if (bus.write_user_buffer_data !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h want=0", bus.write_user_buffer_data); end
    checks++; if (bus.write_control_fixed_location !== 1'b1 || bus.read_control_fixed_location !== 1'b1) begin
      failures++; $display("FAIL tie_fixed got=%b%b want=11", bus.write_control_fixed_location, bus.read_control_fixed_location); end
    checks++; if (bus.write_control_write_length !== 28'd4 || bus.read_control_read_length !== 28'd4) begin
      failures++; $display("FAIL tie_length got=%0d/%0d want=4/4", bus.write_control_write_length, bus.read_control_read_length); end
    do_reset();
  endtask

  task automatic test_single_write();
    int g;
    clear_logs(); wr_mode = 0; auto_drop = 1;
    write_nx = 2'b01; addr_nx = '0; addr_nx[AW-1:0] = 28'h0000100;
    wdata_nx = '0; wdata_nx[DW-1:0] = 32'hDEADBEEF; valid_nx = 2'b01;
    wait_rsp(1, 40);
    repeat (2) tick();
    write_nx = '0;
    g = (grant_cyc.size() > 0) ? grant_cyc[0] : -100;
    checks++; if (grant_cyc.size() !== 1 || grant_id[0] !== 1'b0) begin failures++; $display("FAIL wr_grant got=%0d grants want=1 to req0", grant_cyc.size()); end
    checks++; if (wr_go_n !== 1 || push_n !== 1) begin failures++; $display("FAIL wr_pulses got go=%0d push=%0d want=1/1", wr_go_n, push_n); end
    checks++; if (wr_go_cyc !== g + 1) begin failures++; $display("FAIL wr_go_cycle got=%0d want=%0d", wr_go_cyc, g + 1); end
    checks++; if (go_bases.size() !== 1 || go_bases[0] !== 28'h0000100) begin failures++; $display("FAIL wr_base got=%h want=0000100", bus.write_control_write_base); end
    checks++; if (push_data_log !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_data got=%h want=deadbeef", push_data_log); end
    checks++; if (rsp_cyc.size() !== 1) begin failures++; $display("FAIL wr_rsp_count got=%0d want=1", rsp_cyc.size()); end
    else begin
      checks++; if (rsp_id[0] !== 1'b0 || rsp_cyc[0] !== g + 4) begin failures++; $display("FAIL wr_rsp got id=%0d cyc=%0d want id=0 cyc=%0d", rsp_id[0], rsp_cyc[0], g + 4); end
      checks++; if (rsp_err[0] !== 1'b0 || rsp_rd[0] !== 32'h0) begin failures++; $display("FAIL wr_rsp_fields got err=%b rdata=%h want 0/0", rsp_err[0], rsp_rd[0]); end
    end
    checks++; if (rd_go_n !== 0) begin failures++; $display("FAIL wr_no_read got=%0d want=0", rd_go_n); end
  endtask

  task automatic test_single_read();
    int g;
    clear_logs(); rd_mode = 0; auto_drop = 1;
    write_nx = 2'b00; addr_nx = '0; addr_nx[2*AW-1:AW] = 28'h0000200;
    rd_val = 32'h12345678; valid_nx = 2'b10;
    wait_rsp(1, 40);
    repeat (2) tick();
    g = (grant_cyc.size() > 0) ? grant_cyc[0] : -100;
    checks++; if (grant_cyc.size() !== 1 || grant_id[0] !== 1'b1) begin failures++; $display("FAIL rd_grant got=%0d grants want=1 to req1", grant_cyc.size()); end
    checks++; if (rd_go_n !== 1 || rd_base_log !== 28'h0000200) begin failures++; $display("FAIL rd_go got n=%0d base=%h want 1/0000200", rd_go_n, rd_base_log); end
    checks++; if (pop_n !== 1) begin failures++; $display("FAIL rd_pop got=%0d want=1", pop_n); end
    checks++; if (rsp_cyc.size() !== 1) begin failures++; $display("FAIL rd_rsp_count got=%0d want=1", rsp_cyc.size()); end
    else begin
      checks++; if (rsp_id[0] !== 1'b1 || rsp_cyc[0] !== g + 5) begin failures++; $display("FAIL rd_rsp got id=%0d cyc=%0d want id=1 cyc=%0d", rsp_id[0], rsp_cyc[0], g + 5); end
      checks++; if (rsp_rd[0] !== 32'h12345678 || rsp_err[0] !== 1'b0) begin failures++; $display("FAIL rd_rsp_fields got rdata=%h err=%b want 12345678/0", rsp_rd[0], rsp_err[0]); end
    end
    checks++; if (bus.rsp_rdata !== 32'h12345678) begin failures++; $display("FAIL rd_hold got=%h want=12345678", bus.rsp_rdata); end
  endtask

  task automatic test_timeout();
    int g;
    clear_logs(); rd_mode = 2; auto_drop = 1;
    write_nx = 2'b00; addr_nx = '0; addr_nx[AW-1:0] = 28'h0000300; valid_nx = 2'b01;
    wait_rsp(1, 60);
    tick();
    g = (grant_cyc.size() > 0) ? grant_cyc[0] : -100;
    checks++; if (grant_cyc.size() !== 1 || grant_id[0] !== 1'b0) begin failures++; $display("FAIL to_grant got=%0d grants want=1 to req0", grant_cyc.size()); end
    checks++; if (rsp_cyc.size() !== 1) begin failures++; $display("FAIL to_rsp_count got=%0d want=1", rsp_cyc.size()); end
    else begin
      checks++; if (rsp_id[0] !== 1'b0 || rsp_cyc[0] !== g + 2 + TO) begin failures++; $display("FAIL to_rsp got id=%0d cyc=%0d want id=0 cyc=%0d", rsp_id[0], rsp_cyc[0], g + 2 + TO); end
      checks++; if (rsp_err[0] !== 1'b1 || rsp_rd[0] !== 32'h0) begin failures++; $display("FAIL to_rsp_fields got err=%b rdata=%h want 1/0", rsp_err[0], rsp_rd[0]); end
    end
    checks++; if (pop_n !== 0) begin failures++; $display("FAIL to_no_pop got=%0d want=0", pop_n); end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    clear_logs(); rd_mode = 2; auto_drop = 1;
    write_nx = 2'b00; addr_nx = '0; addr_nx[2*AW-1:AW] = 28'h0000500; valid_nx = 2'b10;
    wait_grant(1, 10);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_mid_idle got busy=%b rsp=%b want 0/00", bus.busy, bus.rsp_valid); end
    checks++; if (bus.rsp_error !== 1'b0 || bus.read_control_read_base !== 28'h0) begin failures++; $display("FAIL rst_mid_regs got err=%b base=%h want 0/0", bus.rsp_error, bus.read_control_read_base); end
    n = rsp_cyc.size();
    repeat (2) tick();
    checks++; if (rsp_cyc.size() !== n) begin failures++; $display("FAIL rst_mid_no_rsp got=%0d want=%0d", rsp_cyc.size(), n); end
    reset = 1'b0;
    clear_logs(); rd_mode = 0; rd_val = 32'h0BADCAFE;
    addr_nx = {28'h0000700, 28'h0000600}; valid_nx = 2'b11;
    wait_grant(1, 10);
    checks++; if (grant_cyc.size() !== 1 || grant_id[0] !== 1'b0) begin failures++; $display("FAIL rst_first_grant got n=%0d want req0 first", grant_cyc.size()); end
    wait_rsp(2, 40);
    checks++; if (grant_id.size() !== 2 || grant_id[1] !== 1'b1) begin failures++; $display("FAIL rst_second_grant got n=%0d want req1 second", grant_id.size()); end
    valid_nx = 2'b00;
    tick();
  endtask

  task automatic test_buffer_full();
    int g;
    clear_logs(); wr_mode = 0; auto_drop = 1; full_nx = 1'b1;
    write_nx = 2'b01; addr_nx = '0; addr_nx[AW-1:0] = 28'h0000400;
    wdata_nx = '0; wdata_nx[DW-1:0] = 32'hCAFEF00D; valid_nx = 2'b01;
    wait_grant(1, 10);
    g = (grant_cyc.size() > 0) ? grant_cyc[0] : -100;
    repeat (5) tick();
    checks++; if (wr_go_n !== 0 || push_n !== 0) begin failures++; $display("FAIL full_hold got go=%0d push=%0d want 0/0", wr_go_n, push_n); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL full_busy got=%b want=1", bus.busy); end
    full_nx = 1'b0;
    wait_rsp(1, 30);
    repeat (2) tick();
    write_nx = '0;
    checks++; if (wr_go_n !== 1 || push_n !== 1 || push_full_err !== 0) begin failures++; $display("FAIL full_pulse got go=%0d push=%0d pushfull=%0d want 1/1/0", wr_go_n, push_n, push_full_err); end
    checks++; if (wr_go_cyc !== g + 6) begin failures++; $display("FAIL full_go_cycle got=%0d want=%0d", wr_go_cyc, g + 6); end
    checks++; if (push_data_log !== 32'hCAFEF00D) begin failures++; $display("FAIL full_data got=%h want=cafef00d", push_data_log); end
    checks++; if (rsp_cyc.size() !== 1 || rsp_cyc[0] !== g + 9) begin failures++; $display("FAIL full_rsp got n=%0d want 1 at cyc %0d", rsp_cyc.size(), g + 9); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_base;
    do_reset();
    wr_mode = 1; auto_drop = 0;
    write_nx = 2'b11; addr_nx = {28'h0000B00, 28'h0000A00};
    wdata_nx = {32'hBBBB0001, 32'hAAAA0000}; valid_nx = 2'b11;
    wait_rsp(4, 60);
    valid_nx = 2'b00;
    repeat (2) tick();
    write_nx = '0;
    checks++; if (grant_cyc.size() !== 4 || rsp_cyc.size() !== 4 || go_bases.size() !== 4) begin
      failures++; $display("FAIL b2b_count got grants=%0d rsps=%0d gos=%0d want 4/4/4", grant_cyc.size(), rsp_cyc.size(), go_bases.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        exp_base = (i % 2 == 1) ? 28'h0000B00 : 28'h0000A00;
        checks++; if (grant_id[i] !== ((i % 2) == 1)) begin failures++; $display("FAIL b2b_order[%0d] got=%0d want=%0d", i, grant_id[i], i % 2); end
        checks++; if (rsp_cyc[i] !== grant_cyc[i] + 4 || rsp_id[i] !== grant_id[i]) begin
          failures++; $display("FAIL b2b_rsp[%0d] got cyc=%0d id=%0d want cyc=%0d id=%0d", i, rsp_cyc[i], rsp_id[i], grant_cyc[i] + 4, grant_id[i]); end
        checks++; if (go_bases[i] !== exp_base) begin failures++; $display("FAIL b2b_base[%0d] got=%h want=%h", i, go_bases[i], exp_base); end
      end
      checks++; if (grant_cyc[1] !== rsp_cyc[0] + 1) begin failures++; $display("FAIL b2b_regrant got=%0d want=%0d", grant_cyc[1], rsp_cyc[0] + 1); end
    end
    checks++; if (overlap_err !== 0) begin failures++; $display("FAIL b2b_overlap got=%0d want=0", overlap_err); end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_single_write();
    test_single_read();
    test_timeout();
    test_reset_mid_wait();
    test_buffer_full();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
